// File: rtl/ps2_key_fifo.sv
// PS/2 set-2 keyboard front end: synchronizes the pad, receives frames, decodes make/break
// prefixes and shift, maps key presses to ASCII and buffers them in a fall-through FIFO.
//
// state   | meaning
// IDLE    | waiting for a make code or a prefix byte
// BRK     | F0 seen; next byte is a break code
// EXT     | E0 seen; next byte is an extended make or F0
// EXT_BRK | E0 F0 seen; next byte is an extended break (ignored)
module ps2_key_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_ascii,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       shift_held,
  output logic       overflow,
  output logic       frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} dec_state_t;

  logic [2:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          fall;
  logic          bit_in;
  logic [3:0]    bit_cnt;
  logic [9:0]    frame_sr;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_expire;
  logic          byte_valid;
  logic [7:0]    byte_q;

  dec_state_t    state, state_nxt;
  logic          make_ev, brk_ev;
  logic          is_shift;
  logic [7:0]    last_make;
  logic          map_ok;
  logic [7:0]    map_ascii;
  logic [7:0]    push_ascii;
  logic          push;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, pop, wr_en;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync <= 3'b111;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  assign fall   = clk_sync[2] & ~clk_sync[1];
  assign bit_in = dat_sync[1];

  // Inactivity timer: reloaded on every PS/2 clock edge, counts down only inside a frame.
  assign tmo_expire = (bit_cnt != 4'd0) && (tmo_cnt == '0) && !fall;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt    <= 4'd0;
      frame_sr   <= '0;
      tmo_cnt    <= '0;
      byte_valid <= 1'b0;
      byte_q     <= 8'h00;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        tmo_cnt <= TW'(TIMEOUT - 1);
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          // frame_sr[0] start, [8:1] data, [9] parity; odd parity over data+parity
          if (!frame_sr[0] && bit_in && (^frame_sr[9:1])) begin
            byte_valid <= 1'b1;
            byte_q     <= frame_sr[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          frame_sr <= {bit_in, frame_sr[9:1]};
          bit_cnt  <= bit_cnt + 4'd1;
        end
      end else if (tmo_expire) begin
        bit_cnt   <= 4'd0;
        frame_err <= 1'b1;
      end else if (bit_cnt != 4'd0) begin
        tmo_cnt <= tmo_cnt - TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    make_ev   = 1'b0;
    brk_ev    = 1'b0;
    if (byte_valid) begin
      case (state)
        IDLE: begin
          if (byte_q == 8'hF0)      state_nxt = BRK;
          else if (byte_q == 8'hE0) state_nxt = EXT;
          else                      make_ev   = 1'b1;
        end
        BRK: begin
          brk_ev    = 1'b1;
          state_nxt = IDLE;
        end
        EXT:     state_nxt = (byte_q == 8'hF0) ? EXT_BRK : IDLE;
        EXT_BRK: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign is_shift = (byte_q == 8'h12) || (byte_q == 8'h59);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      shift_held <= 1'b0;
      last_make  <= 8'h00;
    end else if (make_ev) begin
      if (is_shift)               shift_held <= 1'b1;
      else if (byte_q != last_make) last_make <= byte_q;
    end else if (brk_ev) begin
      if (is_shift)               shift_held <= 1'b0;
      if (byte_q == last_make)    last_make  <= 8'h00;
    end
  end

  always_comb begin
    map_ok    = 1'b1;
    map_ascii = 8'h00;
    case (byte_q)
      8'h1C: map_ascii = 8'h61;  8'h32: map_ascii = 8'h62;  8'h21: map_ascii = 8'h63;
      8'h23: map_ascii = 8'h64;  8'h24: map_ascii = 8'h65;  8'h2B: map_ascii = 8'h66;
      8'h34: map_ascii = 8'h67;  8'h33: map_ascii = 8'h68;  8'h43: map_ascii = 8'h69;
      8'h3B: map_ascii = 8'h6A;  8'h42: map_ascii = 8'h6B;  8'h4B: map_ascii = 8'h6C;
      8'h3A: map_ascii = 8'h6D;  8'h31: map_ascii = 8'h6E;  8'h44: map_ascii = 8'h6F;
      8'h4D: map_ascii = 8'h70;  8'h15: map_ascii = 8'h71;  8'h2D: map_ascii = 8'h72;
      8'h1B: map_ascii = 8'h73;  8'h2C: map_ascii = 8'h74;  8'h3C: map_ascii = 8'h75;
      8'h2A: map_ascii = 8'h76;  8'h1D: map_ascii = 8'h77;  8'h22: map_ascii = 8'h78;
      8'h35: map_ascii = 8'h79;  8'h1A: map_ascii = 8'h7A;
      8'h45: map_ascii = 8'h30;  8'h16: map_ascii = 8'h31;  8'h1E: map_ascii = 8'h32;
      8'h26: map_ascii = 8'h33;  8'h25: map_ascii = 8'h34;  8'h2E: map_ascii = 8'h35;
      8'h36: map_ascii = 8'h36;  8'h3D: map_ascii = 8'h37;  8'h3E: map_ascii = 8'h38;
      8'h46: map_ascii = 8'h39;
      8'h29: map_ascii = 8'h20;  8'h5A: map_ascii = 8'h0D;  8'h66: map_ascii = 8'h08;
      default: map_ok = 1'b0;
    endcase
  end

  // Shift only applies to letters, which all map into the lowercase range.
  assign push_ascii = (shift_held && map_ascii >= 8'h61) ? (map_ascii - 8'h20) : map_ascii;
  assign push       = make_ev && !is_shift && (byte_q != last_make) && map_ok;

  assign key_valid = (wr_ptr != rd_ptr);
  assign full      = ((wr_ptr - rd_ptr) == (AW + 1)'(FIFO_DEPTH));
  assign pop       = key_valid && key_ready;
  assign wr_en     = push && (!full || pop);
  assign key_ascii = key_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_ascii;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW + 1)'(1);
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule
